// File: rtl/pipelined_adder.sv
// pipelined_adder: slice-pipelined two's-complement adder/subtractor with valid/ready on both sides.
// Latency: STAGES cycles from acceptance to out_valid; one result per cycle while out_ready=1.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready in the same cycle.
// Optional flags: define PIPELINED_ADDER_FLAGS_EN to compute out_overflow/out_zero (tied 0 otherwise).

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module pipelined_adder #(
  parameter int WIDTH  = `WORD_SIZE,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int SLICE = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must be in 1..8 and divide WIDTH");
  end

  // Register k holds the operand set after slice k has been added: skewed operands
  // (upper slices still to be consumed), deskewed partial sum (lower slices done), slice carry.
  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];

  // Per-stage sources and next values.
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_nxt;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];

  // Whole pipeline moves as one unit; a bubble only moves when everything moves.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage sources: stage 0 from the ports (B inverted and carry forced for subtract), stage k from register k-1.
  always_comb begin
    logic [SLICE:0] part;
    part     = '0;
    a_src[0] = in_a;
    b_src[0] = in_sub ? ~in_b : in_b;
    s_src[0] = '0;
    c_src[0] = in_sub | in_carry;
    v_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = sum_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_src[k][k*SLICE +: SLICE]} + {1'b0, b_src[k][k*SLICE +: SLICE]}
           + {{SLICE{1'b0}}, c_src[k]};
      s_nxt[k]                   = s_src[k];
      s_nxt[k][k*SLICE +: SLICE] = part[SLICE-1:0];
      c_nxt[k]                   = part[SLICE];
    end
  end

  // Shift all stages on adv; data is only captured for valid slots so idle outputs keep their last value (0 after reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= v_src;
      for (int k = 0; k < STAGES; k++) begin
        if (v_src[k]) begin
          a_q[k]   <= a_src[k];
          b_q[k]   <= b_src[k];
          sum_q[k] <= s_nxt[k];
          c_q[k]   <= c_nxt[k];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_carry = c_q[STAGES-1];

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic ovf_q;
  logic zero_q;
  logic ovf_nxt;
  logic zero_nxt;

  // Flags of the final stage: operand MSBs arrive with the top slice, zero looks at the completed sum.
  always_comb begin
    ovf_nxt  = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1])
            && (s_nxt[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
    zero_nxt = (s_nxt[STAGES-1] == '0);
  end

  // Flag registers load together with the final-stage result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv && v_src[STAGES-1]) begin
      ovf_q  <= ovf_nxt;
      zero_q <= zero_nxt;
    end
  end

  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;
`else
  assign out_overflow = 1'b0;
  assign out_zero     = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: drives WIDTH=32 builds with STAGES=4, 1 and 8 from one shared input bus.
// Directed table, stall stream, mid-operation reset and a random stream against a scoreboard model.
// Each DUT applies its own in_ready to the shared bus; a per-DUT queue tracks what it accepted.

module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  localparam int LAT [3] = '{4, 1, 8};

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_carry;
  logic        out_ready;
  logic        in_ready     [3];
  logic        out_valid    [3];
  logic [31:0] out_sum      [3];
  logic        out_carry    [3];
  logic        out_overflow [3];
  logic        out_zero     [3];

  int   errors = 0;
  int   checks = 0;
  int   pushes [3] = '{0, 0, 0};
  int   pops   [3] = '{0, 0, 0};
  res_t q [3][$];
  res_t mon_e;
  vec_t tbl [8];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_carry(in_carry),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(out_sum[0]),
    .out_carry(out_carry[0]), .out_overflow(out_overflow[0]), .out_zero(out_zero[0]));

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_carry(in_carry),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(out_sum[1]),
    .out_carry(out_carry[1]), .out_overflow(out_overflow[1]), .out_zero(out_zero[1]));

  pipelined_adder #(.WIDTH(32), .STAGES(8)) u_s8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_carry(in_carry),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(out_sum[2]),
    .out_carry(out_carry[2]), .out_overflow(out_overflow[2]), .out_zero(out_zero[2]));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow as a range check.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    res_t        r;
    logic [32:0] full;
    longint      sr;
    if (sub) begin
      r.sum   = a - b;
      r.carry = (a >= b);
      sr      = longint'($signed(a)) - longint'($signed(b));
    end else begin
      full    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r.sum   = full[31:0];
      r.carry = full[32];
      sr      = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    r.ovf  = FLAGS && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    r.zero = FLAGS && (r.sum == 32'd0);
    return r;
  endfunction

  // Scoreboard: sample the values the next rising edge will see.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        q[d].delete();
      end else begin
        if (out_valid[d] && out_ready) begin
          pops[d]++;
          if (q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out dut%0d: got sum %0h, required no output", d, out_sum[d]);
          end else begin
            mon_e = q[d].pop_front();
            chk($sformatf("sb_sum dut%0d", d), out_sum[d], mon_e.sum);
            chk($sformatf("sb_carry dut%0d", d), out_carry[d], mon_e.carry);
            chk($sformatf("sb_ovf dut%0d", d), out_overflow[d], mon_e.ovf);
            chk($sformatf("sb_zero dut%0d", d), out_zero[d], mon_e.zero);
          end
        end
        if (in_valid && in_ready[d]) begin
          pushes[d]++;
          q[d].push_back(model(in_a, in_b, in_sub, in_carry));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   i;
    int   cyc;
    int   base;
    logic acc;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{32'h00000007, 32'h00000007, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{32'h12345678, 32'h0000FFFF, 1'b0, 1'b1, 32'h12355678, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; in_carry = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_outputs dut%0d", d),
          {out_valid[d], out_sum[d], out_carry[d], out_overflow[d], out_zero[d]}, 64'd0);
      chk($sformatf("reset_in_ready dut%0d", d), in_ready[d], 1'b1);
    end

    // Directed vectors: exact latency per build plus STAGES=4 result fields.
    for (int v = 0; v < 8; v++) begin
      in_a = tbl[v].a; in_b = tbl[v].b; in_sub = tbl[v].sub; in_carry = tbl[v].cin;
      in_valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        if (c == 1) in_valid = 1'b0;
        for (int d = 0; d < 3; d++)
          chk($sformatf("latency v%0d c%0d dut%0d", v, c, d), out_valid[d], c == LAT[d]);
        if (c == 4) begin
          chk($sformatf("tbl_sum v%0d", v), out_sum[0], tbl[v].sum);
          chk($sformatf("tbl_carry v%0d", v), out_carry[0], tbl[v].carry);
          chk($sformatf("tbl_ovf v%0d", v), out_overflow[0], tbl[v].ovf & FLAGS);
          chk($sformatf("tbl_zero v%0d", v), out_zero[0], tbl[v].zero & FLAGS);
        end
      end
    end

    // Stream of 8 with a 3-cycle output stall mid-stream.
    base = pops[0]; i = 0; cyc = 0;
    in_sub = 1'b0; in_carry = 1'b0;
    while (i < 8 && cyc < 200) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid  = 1'b1;
      in_a      = i;
      in_b      = 32'h10 * i;
      #1;
      if (cyc >= 6 && cyc < 9) begin
        chk($sformatf("stall_in_ready c%0d", cyc), in_ready[0], 1'b0);
        chk($sformatf("stall_out_valid c%0d", cyc), out_valid[0], 1'b1);
        chk($sformatf("stall_hold_sum c%0d", cyc), out_sum[0], 32'h22);
      end
      acc = in_ready[0];
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_accepted", i, 8);
    repeat (12) @(posedge clk);
    #1 chk("stream_result_count", pops[0] - base, 8);

    // Reset mid-operation.
    in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1 in_a = 32'd2; in_b = 32'd2;
    @(posedge clk); #1 in_a = 32'd3; in_b = 32'd3; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
    for (int d = 0; d < 3; d++)
      chk($sformatf("post_reset_in_ready dut%0d", d), in_ready[d], 1'b1);
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 3; d++)
        chk($sformatf("post_reset_quiet c%0d dut%0d", c, d),
            {out_valid[d], out_sum[d], out_carry[d], out_overflow[d], out_zero[d]}, 64'd0);
      @(posedge clk); #1;
    end
    in_a = 32'd3; in_b = 32'd4; in_sub = 1'b0; in_carry = 1'b0; in_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid = 1'b0;
      chk($sformatf("after_reset_valid c%0d", c), out_valid[0], c == 4);
    end
    chk("after_reset_sum", out_sum[0], 32'd7);
    repeat (6) @(posedge clk);
    #1;

    // Random stream with random backpressure until the STAGES=8 build has taken 1000 operands.
    base = pushes[2]; cyc = 0;
    while (pushes[2] - base < 1000 && cyc < 6000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      in_b      = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      in_sub    = $urandom_range(0, 1);
      in_carry  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("random_accept_count", pushes[2] - base >= 1000, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("drain_empty dut%0d", d), q[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
